// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 decryption chain: state encoding of the
// pseudo-random generation loop and the default message geometry.
package rc4_pkg;

  localparam int S_SIZE      = 256;
  localparam int MSG_LEN_DEF = 32;
  localparam int MSG_AW_DEF  = 5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_READ_I  = 4'd1,
    ST_LATCH_I = 4'd2,
    ST_READ_J  = 4'd3,
    ST_LATCH_J = 4'd4,
    ST_WRITE_I = 4'd5,
    ST_WRITE_J = 4'd6,
    ST_READ_F  = 4'd7,
    ST_LATCH_F = 4'd8,
    ST_DONE    = 4'd9
  } prga_state_e;

endpackage

// File: rtl/prga_decrypt_if.sv
// Memory-side bus of the PRGA stage: s_memory port, encrypted-message ROM
// port and decrypted-message RAM port. Read data arrives one cycle after the
// address is sampled.
interface prga_decrypt_if #(
  parameter int MSG_AW = 5
);

  logic [7:0]        s_address;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [7:0]        s_q;
  logic [MSG_AW-1:0] enc_address;
  logic [7:0]        enc_q;
  logic [MSG_AW-1:0] dec_address;
  logic [7:0]        dec_data;
  logic              dec_wren;

  modport master (
    output s_address, s_data, s_wren, enc_address,
    output dec_address, dec_data, dec_wren,
    input  s_q, enc_q
  );

  modport slave (
    input  s_address, s_data, s_wren, enc_address,
    input  dec_address, dec_data, dec_wren,
    output s_q, enc_q
  );

endinterface

// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation loop: swaps S entries, forms the keystream
// byte and writes ciphertext XOR keystream into the decrypted-message RAM.
// One-shot: once DONE is reached only reset brings the block back to IDLE.
module prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int MSG_AW  = MSG_AW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_flag,
  output logic            done_flag,
  prga_decrypt_if.master  mem
);

  prga_state_e       state_r;
  prga_state_e       state_next_s;
  logic [7:0]        i_r;
  logic [7:0]        j_r;
  logic [MSG_AW-1:0] k_r;
  logic [7:0]        si_r;
  logic [7:0]        sj_r;
  logic [7:0]        enc_byte_r;
  logic              last_byte_s;

  assign last_byte_s = (k_r == MSG_AW'(MSG_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state sequencing: one cycle per state, eight cycles per byte
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_flag) begin
          state_next_s = ST_READ_I;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ_I:  state_next_s = ST_LATCH_I;
      ST_LATCH_I: state_next_s = ST_READ_J;
      ST_READ_J:  state_next_s = ST_LATCH_J;
      ST_LATCH_J: state_next_s = ST_WRITE_I;
      ST_WRITE_I: state_next_s = ST_WRITE_J;
      ST_WRITE_J: state_next_s = ST_READ_F;
      ST_READ_F:  state_next_s = ST_LATCH_F;
      ST_LATCH_F: begin
        if (last_byte_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_READ_I;
        end
      end
      ST_DONE:    state_next_s = ST_DONE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // Index and operand registers; i and j wrap by natural 8-bit overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      i_r        <= 8'd0;
      j_r        <= 8'd0;
      k_r        <= '0;
      si_r       <= 8'd0;
      sj_r       <= 8'd0;
      enc_byte_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_flag) begin
            i_r <= 8'd1;
            j_r <= 8'd0;
            k_r <= '0;
          end
        end
        ST_LATCH_I: begin
          si_r <= mem.s_q;
          j_r  <= j_r + mem.s_q;
        end
        ST_LATCH_J: sj_r <= mem.s_q;
        ST_READ_F:  enc_byte_r <= mem.enc_q;
        ST_LATCH_F: begin
          if (!last_byte_s) begin
            k_r <= k_r + MSG_AW'(1);
            i_r <= i_r + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobes, addresses and data decoded from the current state
  always_comb begin
    mem.s_address   = 8'd0;
    mem.s_data      = 8'd0;
    mem.s_wren      = 1'b0;
    mem.enc_address = '0;
    mem.dec_address = '0;
    mem.dec_data    = 8'd0;
    mem.dec_wren    = 1'b0;
    done_flag       = 1'b0;
    case (state_r)
      ST_READ_I: mem.s_address = i_r;
      ST_READ_J: mem.s_address = j_r;
      ST_WRITE_I: begin
        mem.s_address = i_r;
        mem.s_data    = sj_r;
        mem.s_wren    = 1'b1;
      end
      ST_WRITE_J: begin
        mem.s_address   = j_r;
        mem.s_data      = si_r;
        mem.s_wren      = 1'b1;
        mem.enc_address = k_r;
      end
      ST_READ_F: mem.s_address = si_r + sj_r;
      ST_LATCH_F: begin
        mem.dec_address = k_r;
        mem.dec_data    = mem.s_q ^ enc_byte_r;
        mem.dec_wren    = 1'b1;
      end
      ST_DONE: done_flag = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Self-checking bench for prga_decrypt: behavioural memories around the DUT
// and a software RC4 (KSA + PRGA) reference model.
module tb_prga_decrypt;
  import rc4_pkg::*;

  localparam int LEN = 32;
  localparam int AW  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_flag = 1'b0;
  logic done_flag;

  prga_decrypt_if #(.MSG_AW(AW)) bus ();

  prga_decrypt #(.MSG_LEN(LEN), .MSG_AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_flag (start_flag),
    .done_flag  (done_flag),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem   [S_SIZE];
  logic [7:0] enc_rom [LEN];
  logic [7:0] dec_ram [LEN];
  logic [7:0] ref_s   [S_SIZE];
  logic [7:0] exp_pt  [LEN];
  logic [7:0] chain_pt[LEN];
  int         s_cnt = 0;
  int         dec_cnt = 0;
  int         dec_log[$];
  int         checks = 0;
  int         errors = 0;

  // Synchronous memories with one-cycle read latency, plus strobe monitors
  always @(posedge clk) begin
    if (bus.s_wren) begin
      s_mem[bus.s_address] <= bus.s_data;
      s_cnt <= s_cnt + 1;
    end
    bus.s_q   <= s_mem[bus.s_address];
    bus.enc_q <= enc_rom[bus.enc_address];
    if (bus.dec_wren) begin
      dec_ram[bus.dec_address] <= bus.dec_data;
      dec_log.push_back(int'(bus.dec_address));
      dec_cnt <= dec_cnt + 1;
    end
  end

  // Reference: standard RC4 keystream generation over a copy of ref_s
  task automatic model_prga();
    logic [7:0] s[S_SIZE];
    int i = 0;
    int j = 0;
    logic [7:0] t;
    for (int n = 0; n < S_SIZE; n++) s[n] = ref_s[n];
    for (int k = 0; k < LEN; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_pt[k] = s[(int'(s[i]) + int'(s[j])) % 256] ^ enc_rom[k];
    end
  endtask

  // Reference: RC4 key scheduling for a 3-byte key
  task automatic model_ksa(input logic [23:0] key);
    logic [7:0] kb[3];
    int j = 0;
    logic [7:0] t;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int n = 0; n < S_SIZE; n++) ref_s[n] = 8'(n);
    for (int n = 0; n < S_SIZE; n++) begin
      j = (j + int'(ref_s[n]) + int'(kb[n % 3])) % 256;
      t = ref_s[n]; ref_s[n] = ref_s[j]; ref_s[j] = t;
    end
  endtask

  // Copy the reference S into the bench s_memory and clear the output RAM
  task automatic load_mem();
    for (int n = 0; n < S_SIZE; n++) s_mem[n] <= ref_s[n];
    for (int n = 0; n < LEN; n++) dec_ram[n] <= 8'h00;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    start_flag = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse start for one cycle, return edges after the start edge until done
  task automatic run_pulse(output int cycles);
    @(negedge clk);
    start_flag = 1'b1;
    @(negedge clk);
    start_flag = 1'b0;
    cycles = 0;
    while (!done_flag && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (done_flag !== 1'b0 || bus.s_wren !== 1'b0 || bus.dec_wren !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: done=%b s_wren=%b dec_wren=%b, required 0/0/0",
               done_flag, bus.s_wren, bus.dec_wren);
    end
    checks++;
    if (bus.s_address !== 8'd0 || bus.enc_address !== 5'd0 || bus.dec_address !== 5'd0
        || bus.s_data !== 8'd0 || bus.dec_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: sa=%0d ea=%0d da=%0d sd=%0d dd=%0d, required all 0",
               bus.s_address, bus.enc_address, bus.dec_address, bus.s_data, bus.dec_data);
    end
  endtask

  task automatic test_idle_hold();
    int s0 = s_cnt;
    int d0 = dec_cnt;
    int bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done_flag !== 1'b0 || bus.s_wren !== 1'b0 || bus.dec_wren !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || s_cnt != s0 || dec_cnt != d0) begin
      errors++;
      $display("FAIL idle_hold: active cycles=%0d s_wr=%0d dec_wr=%0d, required 0/0/0",
               bad, s_cnt - s0, dec_cnt - d0);
    end
  endtask

  task automatic test_identity();
    int cyc;
    int s0, d0, l0, order_bad;
    for (int n = 0; n < S_SIZE; n++) ref_s[n] = 8'(n);
    for (int n = 0; n < LEN; n++) enc_rom[n] = 8'h00;
    load_mem();
    model_prga();
    s0 = s_cnt; d0 = dec_cnt; l0 = dec_log.size();
    run_pulse(cyc);
    checks++;
    if (cyc != 8 * LEN) begin
      errors++;
      $display("FAIL identity_cycles: got %0d, required %0d", cyc, 8 * LEN);
    end
    @(negedge clk);
    checks++;
    if (dec_ram[0] !== 8'h02 || dec_ram[1] !== 8'h05) begin
      errors++;
      $display("FAIL identity_first: got %h %h, required 02 05", dec_ram[0], dec_ram[1]);
    end
    for (int n = 0; n < LEN; n++) begin
      checks++;
      if (dec_ram[n] !== exp_pt[n]) begin
        errors++;
        $display("FAIL identity_byte[%0d]: got %h, required %h", n, dec_ram[n], exp_pt[n]);
      end
    end
    checks++;
    if (dec_cnt - d0 != LEN || s_cnt - s0 != 2 * LEN) begin
      errors++;
      $display("FAIL identity_pulses: dec=%0d s=%0d, required %0d %0d",
               dec_cnt - d0, s_cnt - s0, LEN, 2 * LEN);
    end
    order_bad = 0;
    for (int n = 0; n < LEN; n++) begin
      if (l0 + n >= dec_log.size() || dec_log[l0 + n] != n) order_bad++;
    end
    checks++;
    if (order_bad != 0) begin
      errors++;
      $display("FAIL identity_order: %0d out-of-order dec addresses, required 0", order_bad);
    end
  endtask

  task automatic test_after_done();
    int s0 = s_cnt;
    int d0 = dec_cnt;
    int bad = 0;
    @(negedge clk); start_flag = 1'b0;
    @(negedge clk); start_flag = 1'b1;
    @(negedge clk); start_flag = 1'b0;
    @(negedge clk); start_flag = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_flag !== 1'b1 || bus.s_address !== 8'd0 || bus.enc_address !== 5'd0
          || bus.dec_address !== 5'd0) bad++;
    end
    start_flag = 1'b0;
    checks++;
    if (bad != 0 || s_cnt != s0 || dec_cnt != d0) begin
      errors++;
      $display("FAIL after_done: bad cycles=%0d s_wr=%0d dec_wr=%0d, required 0/0/0",
               bad, s_cnt - s0, dec_cnt - d0);
    end
  endtask

  task automatic test_full_chain();
    int cyc;
    apply_reset();
    model_ksa(24'h00033C);
    for (int n = 0; n < LEN; n++) enc_rom[n] = 8'($urandom_range(0, 255));
    load_mem();
    model_prga();
    run_pulse(cyc);
    checks++;
    if (cyc != 8 * LEN) begin
      errors++;
      $display("FAIL chain_cycles: got %0d, required %0d", cyc, 8 * LEN);
    end
    @(negedge clk);
    for (int n = 0; n < LEN; n++) begin
      chain_pt[n] = exp_pt[n];
      checks++;
      if (dec_ram[n] !== exp_pt[n]) begin
        errors++;
        $display("FAIL chain_byte[%0d]: got %h, required %h", n, dec_ram[n], exp_pt[n]);
      end
    end
  endtask

  task automatic test_midloop_reset();
    int n, cyc;
    int d0;
    apply_reset();
    load_mem();
    d0 = dec_cnt;
    @(negedge clk);
    start_flag = 1'b1;
    @(negedge clk);
    start_flag = 1'b0;
    n = 0;
    while (!(bus.s_wren === 1'b1 && dec_cnt - d0 == 5) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400 || bus.s_address !== 8'd6) begin
      errors++;
      $display("FAIL midloop_reach: waited %0d cycles, s_address=%0d, required byte-5 write of 6",
               n, bus.s_address);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_wren !== 1'b0 || bus.dec_wren !== 1'b0 || done_flag !== 1'b0
        || bus.s_address !== 8'd0) begin
      errors++;
      $display("FAIL midloop_reset: s_wren=%b dec_wren=%b done=%b sa=%0d, required 0/0/0/0",
               bus.s_wren, bus.dec_wren, done_flag, bus.s_address);
    end
    reset = 1'b0;
    load_mem();
    run_pulse(cyc);
    checks++;
    if (cyc != 8 * LEN) begin
      errors++;
      $display("FAIL restart_cycles: got %0d, required %0d", cyc, 8 * LEN);
    end
    @(negedge clk);
    for (int m = 0; m < LEN; m++) begin
      checks++;
      if (dec_ram[m] !== chain_pt[m]) begin
        errors++;
        $display("FAIL restart_byte[%0d]: got %h, required %h", m, dec_ram[m], chain_pt[m]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_identity();
    test_after_done();
    test_full_chain();
    test_midloop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
